mist1032isa_uart_receiver: RTL and testbench
============================================

# mist1032isa_uart_receiver

Receive half of the MIST1032ISA UART: recovers 8N1 frames from the asynchronous `iUART_RXD` line and presents each byte through a valid/acknowledge register interface. It oversamples x4 using a divided baud tick with the same divisor semantics as the UART transmitter, so both directions share one baud setting. Start-bit validation, mid-bit sampling, framing-error and overrun detection are included. Everything runs in the single system clock domain.

## Interface
- `BAUDRATE_FIXED`, 1'b1, 0: divisor from `iEXTBAUD_COUNT`; 1: divisor from `BAUDRATE_COUNTER`
- `BAUDRATE_COUNTER`, 20'd108, (Clock / Baudrate) / 4 - 1; must be >= 3
- `iCLOCK` input 1 system clock; all logic on rising edge
- `iRESET` input 1 reset, asynchronous, active-high
- `iEXTBAUD_COUNT` input 20 runtime divisor, used when `BAUDRATE_FIXED`=0; must be >= 3
- `iUART_RXD` input 1 serial line, asynchronous, idle high
- `oRX_VALID` output 1 received byte held in `oRX_DATA`
- `oRX_DATA` output 8 received byte, LSB = first data bit
- `iRX_ACK` input 1 consume the held byte; ignored when `oRX_VALID`=0
- `oRX_BUSY` output 1 frame in progress (state != IDLE)
- `oRX_FRAME_ERR` output 1 one-cycle pulse: stop bit sampled low
- `oRX_OVERRUN` output 1 one-cycle pulse: good byte dropped because the holding register was full

## Operation
- Input path: 2-FF synchronizer on `iUART_RXD` (reset value 1), then a 1-bit history register `prev` (reset value 1). A falling edge is `prev`=1 and synchronized=0.
- Baud tick: 20-bit counter. When counter >= divisor, it returns to 0 and `tick` is 1 for that cycle; otherwise it increments. Tick period is divisor+1 clocks. The counter and 2-bit sub-counter clear in the same cycle IDLE->START is taken.
- Each tick increments the sub-counter mod 4. The sample point is a tick at which the sub-counter reads 1 before incrementing. This is 2 ticks after detection, then every 4 ticks.
- FSM:
  - IDLE: on falling edge, go to START.
  - START: at the sample point, synchronized=1 -> IDLE (false start, no flag); otherwise go to DATA with bit index 0.
  - DATA: at each sample point, shift the synchronized bit into bit[index]. After index 7 is sampled, go to STOP.
  - STOP: at the sample point, go to IDLE.
    - Stop=1: deliver the byte (see below).
    - Stop=0: pulse `oRX_FRAME_ERR` and discard the byte.
- Return from STOP to IDLE is immediate. A new start needs a fresh 1->0 edge, so a line held low after a framing error does not retrigger.
- Delivery:
  - `oRX_VALID`=0: load `oRX_DATA`, set `oRX_VALID`=1.
  - `oRX_VALID`=1 with `iRX_ACK`=1 in the same cycle: load the new byte, `oRX_VALID` stays 1, no overrun.
  - `oRX_VALID`=1 without ack: keep the old byte, pulse `oRX_OVERRUN`, drop the new byte.
- `iRX_ACK` with `oRX_VALID`=1 and no delivery: clear `oRX_VALID` next cycle. `oRX_DATA` keeps its last value.

## Timing
- Reset values: `oRX_VALID`=0, `oRX_DATA`=8'h00, `oRX_BUSY`=0, `oRX_FRAME_ERR`=0, `oRX_OVERRUN`=0. FSM is IDLE; baud counter, sub-counter, index and shift register are 0.
- Reset mid-frame aborts the frame with no flags. After release, the block waits for a new falling edge.
- Line-fall to IDLE->START: 3 clocks (2 synchronizer stages, then edge registered).
- With D = divisor + 1:
  - start sample at detection + 2D clocks
  - data bit k at detection + 2D + 4D(k+1)
  - stop bit at detection + 2D + 36D
- `oRX_VALID` / flags assert in the cycle after the stop sample.
- Changing `iEXTBAUD_COUNT` mid-frame takes effect at the next tick comparison. The >= compare prevents counter runaway.
- Flags are single-cycle, never sticky.

## Test plan
- Reset, `BAUDRATE_COUNTER`=4 (D=5, 20 clocks/bit): drive 8N1 byte 8'hA5 with 20-clock bits -> `oRX_VALID`=1, `oRX_DATA`=8'hA5 one clock after the stop sample. `oRX_BUSY` is high from detection to the stop sample. No flags.
- Glitch: pull RXD low for 6 clocks, then high -> START entered, then IDLE at the sample point. `oRX_VALID` stays 0, no flags. A following 8'h3C frame is received correctly.
- Framing error: byte 8'h55 with stop bit driven 0 -> `oRX_FRAME_ERR` pulses 1 cycle, `oRX_VALID` stays 0. Line held low afterwards produces no new frame until it goes high and falls again.
- Overrun: receive 8'h11 without ack, then 8'h22 -> `oRX_OVERRUN` pulses 1 cycle, `oRX_DATA` stays 8'h11. Ack asserted in the delivery cycle of a third byte 8'h33 -> `oRX_DATA`=8'h33, `oRX_VALID` stays 1, no overrun.
- Runtime divisor: `BAUDRATE_FIXED`=0, `iEXTBAUD_COUNT`=9 (40 clocks/bit), bytes 8'h00 and 8'hFF back-to-back with a single stop bit -> both received in order after acking each.
- Async reset asserted during data bit 4 of 8'hF0 -> all outputs return to reset values immediately. After release, the next full frame 8'h81 is received correctly.

Source files
------------

// File: rtl/mist1032isa_uart_receiver.sv
// 8N1 UART receiver with x4 oversampling, start-bit validation, mid-bit sampling,
// framing-error and overrun reporting behind a valid/ack holding register.
module mist1032isa_uart_receiver #(
  parameter logic        BAUDRATE_FIXED   = 1'b1,
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd108
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic [19:0] iEXTBAUD_COUNT,
  input  logic        iUART_RXD,
  output logic        oRX_VALID,
  output logic [7:0]  oRX_DATA,
  input  logic        iRX_ACK,
  output logic        oRX_BUSY,
  output logic        oRX_FRAME_ERR,
  output logic        oRX_OVERRUN
);

  // state | meaning
  // IDLE  | waiting for a 1->0 edge on the synchronized line
  // START | start bit detected, confirm it is still low at mid-bit
  // DATA  | sampling 8 data bits, LSB first
  // STOP  | sampling the stop bit, then deliver or flag framing error
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_next;
  logic        sync1, sync2, prev;
  logic [19:0] baud_cnt, divisor;
  logic [1:0]  sub_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        fall, tick, sample, start_go;
  logic        shift_en, deliver, frame_bad;

  assign divisor  = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
  assign fall     = prev & ~sync2;
  // >= rather than == so a divisor lowered mid-count cannot run the counter away
  assign tick     = (baud_cnt >= divisor);
  assign sample   = tick && (sub_cnt == 2'd1);
  assign start_go = (state == IDLE) && fall;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= iUART_RXD;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      baud_cnt <= 20'd0;
      sub_cnt  <= 2'd0;
    end else if (start_go) begin
      baud_cnt <= 20'd0;
      sub_cnt  <= 2'd0;
    end else if (tick) begin
      baud_cnt <= 20'd0;
      sub_cnt  <= sub_cnt + 2'd1;
    end else begin
      baud_cnt <= baud_cnt + 20'd1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fall) state_next = START;
      START: if (sample) state_next = sync2 ? IDLE : DATA;
      DATA:  if (sample && (bit_idx == 3'd7)) state_next = STOP;
      STOP:  if (sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oRX_BUSY  = (state != IDLE);
    shift_en  = (state == DATA) && sample;
    deliver   = (state == STOP) && sample && sync2;
    frame_bad = (state == STOP) && sample && !sync2;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if ((state == START) && sample) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      shift_reg[bit_idx] <= sync2;
      bit_idx            <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      oRX_VALID     <= 1'b0;
      oRX_DATA      <= 8'h00;
      oRX_FRAME_ERR <= 1'b0;
      oRX_OVERRUN   <= 1'b0;
    end else begin
      oRX_FRAME_ERR <= frame_bad;
      oRX_OVERRUN   <= 1'b0;
      if (deliver) begin
        // an ack in the delivery cycle frees the slot for the new byte
        if (!oRX_VALID || iRX_ACK) begin
          oRX_DATA  <= shift_reg;
          oRX_VALID <= 1'b1;
        end else begin
          oRX_OVERRUN <= 1'b1;
        end
      end else if (iRX_ACK && oRX_VALID) begin
        oRX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mist1032isa_uart_receiver.sv
// Randomized scoreboard bench for the UART receiver: frame-level reference model
// predicts each delivery / overrun / framing-error event and its cycle.
module tb_mist1032isa_uart_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ext;
  logic        rxd, ack;
  logic        rx_valid, rx_busy, rx_fe, rx_ovr;
  logic [7:0]  rx_data;

  mist1032isa_uart_receiver #(
    .BAUDRATE_FIXED(1'b0),
    .BAUDRATE_COUNTER(20'd4)
  ) dut (
    .iCLOCK(clk),
    .iRESET(rst),
    .iEXTBAUD_COUNT(ext),
    .iUART_RXD(rxd),
    .oRX_VALID(rx_valid),
    .oRX_DATA(rx_data),
    .iRX_ACK(ack),
    .oRX_BUSY(rx_busy),
    .oRX_FRAME_ERR(rx_fe),
    .oRX_OVERRUN(rx_ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int EV_DATA = 0, EV_ERR = 1, EV_OVR = 2;
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  int         n_vec = 0, n_err = 0;
  bit         model_valid = 1'b0;
  logic [7:0] model_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic handle_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_data", rx_data, e.data);
      check("event_cycle", cyc, e.at);
    end
  endtask

  // monitor: turns output activity into events and checks them against the queue
  initial begin
    bit         pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pd = 8'h00;
      end else begin
        if (rx_fe)                                     handle_event(EV_ERR);
        else if (rx_ovr)                               handle_event(EV_OVR);
        else if (rx_valid && !pv)                      handle_event(EV_DATA);
        else if (rx_valid && pv && (rx_data != pd))    handle_event(EV_DATA);
        pv = rx_valid;
        pd = rx_data;
      end
    end
  end

  // mode: 0 no ack, 1 ack in the delivery cycle, 2 ack shortly after delivery
  // abort_t >= 0: assert async reset at that clock of the frame
  task automatic send_frame(input logic [7:0] b, input bit stop, input int mode, input int abort_t);
    int   d, n, bitn;
    ev_t  e;
    d = int'(ext) + 1;
    for (int t = 0; t < 40 * d; t++) begin
      @(negedge clk);
      if (t == 0) begin
        n = cyc;
        if (abort_t < 0) begin
          e.at = n + 3 + 38 * d;
          if (!stop) begin
            e.kind = EV_ERR; e.data = model_data;
          end else if (!model_valid || mode == 1) begin
            e.kind = EV_DATA; e.data = b;
            model_valid = 1'b1; model_data = b;
          end else begin
            e.kind = EV_OVR; e.data = model_data;
          end
          exp_q.push_back(e);
          if (mode == 2) model_valid = 1'b0;
        end
      end
      if (t == 2)            check("busy_before_detect", rx_busy, 1'b0);
      if (t == 3)            check("busy_at_detect", rx_busy, 1'b1);
      if (abort_t < 0 && t == 38 * d + 2) check("busy_before_stop_sample", rx_busy, 1'b1);
      if (abort_t < 0 && t == 38 * d + 3) check("busy_after_stop_sample", rx_busy, 1'b0);
      if (t == abort_t) begin
        check("busy_before_reset", rx_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_frame_err", rx_fe, 1'b0);
        check("rst_overrun", rx_ovr, 1'b0);
        model_valid = 1'b0;
        model_data  = 8'h00;
        rxd = 1'b1;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      bitn = t / (4 * d);
      if (bitn == 0)      rxd = 1'b0;
      else if (bitn <= 8) rxd = b[bitn-1];
      else                rxd = stop;
      ack = (mode == 1 && t == 38 * d + 2) || (mode == 2 && t == 38 * d + 5);
    end
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic glitch();
    int d;
    d = int'(ext) + 1;
    for (int t = 0; t < 2 * d + 10; t++) begin
      @(negedge clk);
      if (t == 3)         check("glitch_busy_start", rx_busy, 1'b1);
      if (t == 2 * d + 3) check("glitch_busy_idle", rx_busy, 1'b0);
      rxd = (t >= 6);
    end
    check("glitch_valid", rx_valid, model_valid);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    ack = 1'b0;
    ext = 20'd4;
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_busy", rx_busy, 1'b0);
    check("reset_frame_err", rx_fe, 1'b0);
    check("reset_overrun", rx_ovr, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 2, -1);
    glitch();
    send_frame(8'h3C, 1'b1, 2, -1);

    send_frame(8'h55, 1'b0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      repeat (20) @(negedge clk);
      check("held_low_idle", rx_busy, 1'b0);
    end
    rxd = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    send_frame(8'h33, 1'b1, 1, -1);
    check("held_after_ack_delivery", rx_valid, 1'b1);

    send_frame(8'hF0, 1'b1, 0, 4 * 5 * 5 + 10);
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, 2, -1);

    ext = 20'd9;
    send_frame(8'h00, 1'b1, 2, -1);
    send_frame(8'hFF, 1'b1, 2, -1);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      bit         stop;
      int         mode;
      ext  = 20'($urandom_range(3, 6));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      mode = $urandom_range(0, 2);
      send_frame(b, stop, mode, -1);
      if (!stop) begin
        rxd = 1'b1;
        repeat (4) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
